// File: rtl/nvdla_csb_sequencer_pkg.sv
// Shared types for the NVDLA CSB command sequencer: queued command record
// and the sequencer FSM state encoding.
package nvdla_package;

  localparam int unsigned CSB_ADDR_W = 16;
  localparam int unsigned CSB_DATA_W = 32;

  typedef struct packed {
    logic [CSB_ADDR_W-1:0] addr;
    logic [CSB_DATA_W-1:0] wdat;
    logic                  write;
    logic                  wait_intr;
  } csb_cmd_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT_RD,
    ST_WAIT_INTR,
    ST_DONE
  } csb_seq_state_t;

endpackage

// File: rtl/nvdla_csb_sequencer_cmd_fifo.sv
// Command queue for the CSB sequencer. Power-of-two depth, pointers wrap
// naturally; push and pop may coincide even when full.
module nvdla_csb_cmd_fifo
  import nvdla_package::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic     clk_i,
  input  logic     rst_ni,
  input  logic     clear_i,
  input  logic     push_i,
  input  csb_cmd_t data_i,
  input  logic     pop_i,
  output csb_cmd_t data_o,
  output logic     full_o,
  output logic     empty_o
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  csb_cmd_t           r_mem [DEPTH];
  logic [PTR_W-1:0]   r_wptr;
  logic [PTR_W-1:0]   r_rptr;
  logic [CNT_W-1:0]   r_count;
  logic               w_push;
  logic               w_pop;

  assign full_o  = (r_count == CNT_W'(DEPTH));
  assign empty_o = (r_count == '0);
  assign w_pop   = pop_i && !empty_o;
  // A pop frees the slot the write lands in, so a full FIFO may still accept.
  assign w_push  = push_i && (!full_o || w_pop);
  assign data_o  = r_mem[r_rptr];

  always_ff @(posedge clk_i) begin
    if (w_push) begin
      r_mem[r_wptr] <= data_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni || clear_i) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_wptr <= r_wptr + 1'b1;
      end
      if (w_pop) begin
        r_rptr <= r_rptr + 1'b1;
      end
      unique case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/nvdla_csb_sequencer.sv
// Issues queued register accesses on the NVDLA CSB one at a time, collects
// read data and optionally stalls for the NVDLA interrupt with a timeout.
module nvdla_csb_sequencer
  import nvdla_package::*;
#(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned TIMEOUT_W  = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 clear_i,
  input  logic                 cmd_valid_i,
  output logic                 cmd_ready_o,
  input  logic [15:0]          cmd_addr_i,
  input  logic [31:0]          cmd_wdat_i,
  input  logic                 cmd_write_i,
  input  logic                 cmd_wait_intr_i,
  output logic                 csb_valid_o,
  input  logic                 csb_ready_i,
  output logic [15:0]          csb_addr_o,
  output logic [31:0]          csb_wdat_o,
  output logic                 csb_write_o,
  output logic                 csb_nposted_o,
  input  logic                 csb_rvalid_i,
  input  logic [31:0]          csb_rdata_i,
  input  logic                 intr_i,
  input  logic [TIMEOUT_W-1:0] timeout_i,
  output logic [31:0]          rdata_o,
  output logic                 rdata_valid_o,
  output logic                 done_o,
  output logic                 busy_o,
  output logic                 timeout_o
);

  csb_seq_state_t       r_state;
  csb_cmd_t             r_cmd;
  logic                 r_csb_valid;
  logic                 r_rd_got;
  logic [TIMEOUT_W-1:0] r_cnt;
  logic [31:0]          r_rdata;
  logic                 r_rdata_valid;
  logic                 r_done;
  logic                 r_timeout;

  csb_cmd_t             w_push_cmd;
  csb_cmd_t             w_head;
  logic                 w_push;
  logic                 w_pop;
  logic                 w_full;
  logic                 w_empty;

  assign w_push_cmd.addr      = cmd_addr_i;
  assign w_push_cmd.wdat      = cmd_wdat_i;
  assign w_push_cmd.write     = cmd_write_i;
  assign w_push_cmd.wait_intr = cmd_wait_intr_i;

  assign w_push = cmd_valid_i && !w_full;
  assign w_pop  = (r_state == ST_IDLE) && !w_empty;

  nvdla_csb_cmd_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_cmd_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .clear_i (clear_i),
    .push_i  (w_push),
    .data_i  (w_push_cmd),
    .pop_i   (w_pop),
    .data_o  (w_head),
    .full_o  (w_full),
    .empty_o (w_empty)
  );

  assign cmd_ready_o   = !w_full;
  assign busy_o        = (r_state != ST_IDLE) || !w_empty;
  assign csb_valid_o   = r_csb_valid;
  assign csb_addr_o    = r_cmd.addr;
  assign csb_wdat_o    = r_cmd.wdat;
  assign csb_write_o   = r_cmd.write;
  assign csb_nposted_o = 1'b0;
  assign rdata_o       = r_rdata;
  assign rdata_valid_o = r_rdata_valid;
  assign done_o        = r_done;
  assign timeout_o     = r_timeout;

  always_ff @(posedge clk_i) begin
    if (!rst_ni || clear_i) begin
      r_state       <= ST_IDLE;
      r_cmd         <= '0;
      r_csb_valid   <= 1'b0;
      r_rd_got      <= 1'b0;
      r_cnt         <= '0;
      r_rdata       <= '0;
      r_rdata_valid <= 1'b0;
      r_done        <= 1'b0;
      r_timeout     <= 1'b0;
    end else begin
      r_rdata_valid <= 1'b0;
      r_done        <= 1'b0;
      unique case (r_state)
        ST_IDLE: begin
          if (!w_empty) begin
            r_cmd       <= w_head;
            r_csb_valid <= 1'b1;
            r_state     <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          if (csb_ready_i) begin
            r_csb_valid <= 1'b0;
            r_cnt       <= '0;
            if (!r_cmd.write) begin
              r_state <= ST_WAIT_RD;
            end else if (r_cmd.wait_intr) begin
              r_state <= ST_WAIT_INTR;
            end else begin
              r_state <= ST_DONE;
              r_done  <= 1'b1;
            end
          end
        end
        ST_WAIT_RD: begin
          // Linger one cycle after capture so done_o trails rdata_valid_o.
          if (r_rd_got) begin
            r_rd_got <= 1'b0;
            r_cnt    <= '0;
            if (r_cmd.wait_intr) begin
              r_state <= ST_WAIT_INTR;
            end else begin
              r_state <= ST_DONE;
              r_done  <= 1'b1;
            end
          end else if (csb_rvalid_i) begin
            r_rdata       <= csb_rdata_i;
            r_rdata_valid <= 1'b1;
            r_rd_got      <= 1'b1;
          end
        end
        ST_WAIT_INTR: begin
          if (intr_i) begin
            r_state <= ST_DONE;
            r_done  <= 1'b1;
          end else if ((timeout_i != '0) && (r_cnt == timeout_i)) begin
            r_timeout <= 1'b1;
            r_state   <= ST_DONE;
            r_done    <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
